// File: rtl/exp_result_bcd_if.sv
// rtl/exp_result_bcd_if.sv - handshake and result bundle for the exponential BCD converter
interface exp_result_bcd_if;
    logic        done;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic [3:0]  int_digit;
    logic [15:0] frac_digits;
    logic        busy;
    logic        valid;

    modport master (
        output done,
        output intpart,
        output fracpart,
        input  int_digit,
        input  frac_digits,
        input  busy,
        input  valid
    );

    modport slave (
        input  done,
        input  intpart,
        input  fracpart,
        output int_digit,
        output frac_digits,
        output busy,
        output valid
    );
endinterface

// File: rtl/exp_result_bcd.sv
// rtl/exp_result_bcd.sv - converts an unsigned 2.16 exponential result into one integer and four fractional BCD digits
module exp_result_bcd (
    input  logic              clk,
    input  logic              rst,
    exp_result_bcd_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic        done_q;
    logic [1:0]  int_q;
    logic [15:0] rem_q;
    logic [2:0]  cnt;
    logic [15:0] digit_sr;

    logic [3:0]  int_digit_q;
    logic [15:0] frac_digits_q;
    logic        busy_q;
    logic        valid_q;

    logic        done_rise;
    logic [19:0] prod;

    // A held-high done only counts once; done_q is cleared in reset so a
    // done already high at release is seen as a fresh edge.
    assign done_rise = bus.done & ~done_q;

    // Remainder times ten: the carry out of bit 15 is the next decimal
    // digit (always 0..9 since rem < 65536), the low 16 bits the new remainder.
    assign prod = ({4'b0000, rem_q} << 3) + ({4'b0000, rem_q} << 1);

    // Conversion sequencer: capture, four digit steps, one settle edge, publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            done_q        <= 1'b0;
            int_q         <= 2'b00;
            rem_q         <= 16'h0000;
            cnt           <= 3'd0;
            digit_sr      <= 16'h0000;
            int_digit_q   <= 4'h0;
            frac_digits_q <= 16'h0000;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            done_q  <= bus.done;
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        int_q  <= bus.intpart;
                        rem_q  <= bus.fracpart;
                        cnt    <= 3'd0;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    // The edge that finds cnt at 4 does no arithmetic; it only
                    // hands over to FINISH, which places valid six edges after capture.
                    if (cnt == 3'd4) begin
                        state <= FINISH;
                    end else begin
                        digit_sr <= {digit_sr[11:0], prod[19:16]};
                        rem_q    <= prod[15:0];
                        cnt      <= cnt + 3'd1;
                    end
                end
                FINISH: begin
                    int_digit_q   <= {2'b00, int_q};
                    frac_digits_q <= digit_sr;
                    valid_q       <= 1'b1;
                    busy_q        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_digit   = int_digit_q;
    assign bus.frac_digits = frac_digits_q;
    assign bus.busy        = busy_q;
    assign bus.valid       = valid_q;
endmodule

// File: doc/exp_result_bcd.md
EXP_RESULT_BCD -- requirements
Module: exp_result_bcd

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock, only clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- done  in  1  completion flag from the exponential stage.
- intpart  in  2  integer part of the exponential result, unsigned 0..3.
- fracpart  in  16  fractional part, unsigned 0.16 fixed point (value = fracpart/65536).
- int_digit  out  4  BCD integer digit, 0..3.
- frac_digits  out  16  four BCD fractional digits; [15:12] = tenths, [3:0] = ten-thousandths.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when int_digit/frac_digits hold a new result.
REQ-002 All outputs SHALL be registered.

Function
REQ-003 The block SHALL keep done_q, a one-cycle-delayed copy of done, and SHALL detect a rising edge as done=1 and done_q=0.
REQ-004 States SHALL be IDLE, CONV and FINISH; the reset state SHALL be IDLE.
REQ-005 IDLE: on a clock edge with a done rising edge, the block SHALL capture intpart into an int register and fracpart into a 16-bit remainder register R, clear the digit counter cnt, set busy=1, and go to CONV.
REQ-006 CONV: each clock edge SHALL compute P = R*10 as a 20-bit value (shift-add: (R<<3)+(R<<1)).
- P[19:16] SHALL shift into a digit shift register, most significant digit first.
- R SHALL load P[15:0].
- cnt SHALL increment.
REQ-007 After the 4th CONV edge (cnt reaches 4), the block SHALL go to FINISH.
REQ-008 FINISH: on the next edge the block SHALL do all of the following, then go to IDLE:
- load int_digit = {2'b00, int register} and frac_digits = digit shift register;
- set valid=1 and busy=0.
REQ-009 valid SHALL be high for exactly one clock period, starting 6 clock edges after the edge that captured done.
REQ-010 valid SHALL deassert on the following edge.
REQ-011 int_digit and frac_digits SHALL hold their values until the next FINISH; they SHALL not change during CONV.
REQ-012 Each digit SHALL be truncated, not rounded; every digit SHALL be in 0..9 for all fracpart values.
REQ-013 A done rising edge while busy=1 SHALL be ignored, not queued.
REQ-014 done held high for many cycles SHALL start exactly one conversion.
- A new conversion requires done to return to 0 and rise again.
- If done is high coming out of reset, done_q=0 makes it count as a rising edge.
REQ-015 Changes on intpart/fracpart after the capture edge SHALL not affect the conversion in progress.

Reset
REQ-016 rst=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, cnt=0, R=0, done_q=0, digit shift register=0;
- int_digit=0, frac_digits=16'h0000, busy=0, valid=0.
REQ-017 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse; the outputs SHALL read zero after reset release.
REQ-018 The first done rising edge sampled after rst returns to 1 SHALL start a conversion normally.

Verification
REQ-019 intpart=1, fracpart=16'hA612 (exp(0.5)), pulse done -> after 6 edges valid=1 for 1 cycle, int_digit=4'h1, frac_digits=16'h6487.
REQ-020 intpart=2, fracpart=16'h75A8 (exp(0.9)) -> int_digit=4'h2, frac_digits=16'h4595; intpart=3, fracpart=16'hFFFF -> int_digit=4'h3, frac_digits=16'h9999.
REQ-021 intpart=1, fracpart=16'h0000 -> frac_digits=16'h0000; fracpart=16'h8000 -> frac_digits=16'h5000.
REQ-022 done held high for 20 cycles -> exactly one valid pulse; a second done rising edge 2 cycles after capture (busy=1) -> no extra conversion, results from the first capture only.
REQ-023 rst=0 asserted during the 2nd CONV cycle -> all outputs 0 asynchronously, no valid pulse.
- A fresh done edge after release gives a correct result.
REQ-024 Random fracpart sweep, 1000 values -> each BCD digit SHALL match floor(fracpart*10^k/65536) mod 10 for k=1..4, digit order MSB first.
